// File: rtl/adc_frame_uart_tx_pkg.sv
// Shared constants and the per-byte UART state type for the ADC frame transmitter.
package adc_uart_pkg;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_BYTES   = 3;
    localparam int         BITS_PER_BYTE = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;
endpackage

// File: rtl/adc_frame_uart_tx_if.sv
// Sample input, control and UART output bundle between the ADC pipeline and the frame transmitter.
interface adc_frame_uart_tx_if;
    logic [15:0] sample;
    logic        sample_valid;
    logic        tx_en;
    logic        clr_ovr;
    logic        txd;
    logic        busy;
    logic        overrun;

    modport master (
        output sample, sample_valid, tx_en, clr_ovr,
        input  txd, busy, overrun
    );

    modport slave (
        input  sample, sample_valid, tx_en, clr_ovr,
        output txd, busy, overrun
    );
endinterface

// File: rtl/adc_frame_uart_tx_byte.sv
// One 8N1 byte on the line: baud counter plus 10-bit shift register.
// A start request in the final STOP cycle chains the next byte with no idle bit.
module uart_byte_tx
    import adc_uart_pkg::*;
#(
    parameter int CLK_DIV = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done
);
    localparam logic [15:0] LAST_CNT = 16'(CLK_DIV - 1);

    uart_state_e               state_r, state_s;
    logic [15:0]               cnt_r, cnt_s;
    logic [2:0]                bit_r, bit_s;
    logic [BITS_PER_BYTE-1:0]  shift_r, shift_s;
    logic                      txd_r, txd_s;
    logic                      done_s, load_s, adv_s, bit_end_s;

    // State, counters and line register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 16'd0;
            bit_r   <= 3'd0;
            shift_r <= {BITS_PER_BYTE{1'b1}};
            txd_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            txd_r   <= txd_s;
        end
    end

    // Bit timing and next-state decode; txd is driven one bit ahead from the shifter
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_s     = bit_r;
        shift_s   = shift_r;
        txd_s     = txd_r;
        done_s    = 1'b0;
        load_s    = 1'b0;
        adv_s     = 1'b0;
        bit_end_s = (cnt_r == LAST_CNT);
        case (state_r)
            IDLE: begin
                if (start) load_s = 1'b1;
                else       cnt_s  = 16'd0;
            end
            START: begin
                if (bit_end_s) begin
                    adv_s   = 1'b1;
                    state_s = DATA;
                    bit_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    adv_s = 1'b1;
                    if (bit_r == 3'd7) state_s = STOP;
                    else               bit_s   = bit_r + 3'd1;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    done_s = 1'b1;
                    if (start) begin
                        load_s = 1'b1;
                    end else begin
                        adv_s   = 1'b1;
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            default: state_s = IDLE;
        endcase

        if (load_s) begin
            state_s = START;
            cnt_s   = 16'd0;
            shift_s = {1'b1, data, 1'b0};
            txd_s   = 1'b0;
        end else if (adv_s) begin
            cnt_s   = 16'd0;
            shift_s = {1'b1, shift_r[BITS_PER_BYTE-1:1]};
            txd_s   = shift_r[1];
        end else begin
            txd_s = txd_r;
        end
    end

    assign txd  = txd_r;
    assign done = done_s;
endmodule

// File: rtl/adc_frame_uart_tx.sv
// Ships each 16-bit ADC result as a 3-byte UART frame (sync, high, low) with a
// one-entry holding register for samples that arrive while a frame is in flight.
module adc_frame_uart_tx
    import adc_uart_pkg::*;
#(
    parameter int         CLK_DIV   = 87,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    adc_frame_uart_tx_if.slave bus
);
    localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

    logic        active_r, active_s;
    logic [1:0]  byte_idx_r, byte_idx_s;
    logic [15:0] frame_r, frame_s;
    logic [15:0] hold_r, hold_s;
    logic        hold_full_r, hold_full_s;
    logic        overrun_r, overrun_s;
    logic        busy_r, busy_s;
    logic        start_s, done_s, txd_s, accept_s, frame_end_s, set_ovr_s;
    logic [7:0]  data_s;

    uart_byte_tx #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .data  (data_s),
        .txd   (txd_s),
        .done  (done_s)
    );

    // Sequencer, frame/hold registers and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r    <= 1'b0;
            byte_idx_r  <= 2'd0;
            frame_r     <= 16'd0;
            hold_r      <= 16'd0;
            hold_full_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            active_r    <= active_s;
            byte_idx_r  <= byte_idx_s;
            frame_r     <= frame_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            overrun_r   <= overrun_s;
            busy_r      <= busy_s;
        end
    end

    // Byte sequencing and sample routing; the hold is only ever full while a frame is active
    always_comb begin
        active_s    = active_r;
        byte_idx_s  = byte_idx_r;
        frame_s     = frame_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        start_s     = 1'b0;
        data_s      = SYNC_BYTE;
        set_ovr_s   = 1'b0;
        accept_s    = bus.sample_valid & bus.tx_en;
        frame_end_s = active_r & done_s & (byte_idx_r == LAST_IDX);

        if (!active_r) begin
            if (accept_s) begin
                start_s    = 1'b1;
                active_s   = 1'b1;
                byte_idx_s = 2'd0;
                frame_s    = bus.sample;
            end else begin
                active_s = 1'b0;
            end
        end else if (frame_end_s) begin
            byte_idx_s = 2'd0;
            if (hold_full_r) begin
                start_s = 1'b1;
                frame_s = hold_r;
                if (accept_s) hold_s      = bus.sample;
                else          hold_full_s = 1'b0;
            end else if (accept_s) begin
                start_s = 1'b1;
                frame_s = bus.sample;
            end else begin
                active_s = 1'b0;
            end
        end else begin
            if (done_s) begin
                start_s    = 1'b1;
                byte_idx_s = byte_idx_r + 2'd1;
                data_s     = (byte_idx_r == 2'd0) ? frame_r[15:8] : frame_r[7:0];
            end else begin
                byte_idx_s = byte_idx_r;
            end
            if (accept_s) begin
                hold_s      = bus.sample;
                hold_full_s = 1'b1;
                set_ovr_s   = hold_full_r;
            end else begin
                hold_s = hold_r;
            end
        end

        overrun_s = set_ovr_s | (overrun_r & ~bus.clr_ovr);
        busy_s    = active_s | hold_full_s;
    end

    assign bus.txd     = txd_s;
    assign bus.busy    = busy_r;
    assign bus.overrun = overrun_r;
endmodule

// File: tb/tb_adc_frame_uart_tx.sv
// Directed bench for adc_frame_uart_tx: decodes the UART line and checks frames, timing and flags.
module tb_adc_frame_uart_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] smp;
    logic        sv;
    logic [2:0]  en;
    logic        clr;
    int          sel;
    logic        txd_m, busy_m, ovr_m;

    int          n_chk = 0;
    int          n_err = 0;
    int          off;
    int          busy_cnt;
    int          inj_off [3];
    logic [15:0] inj_val [3];
    int          clr_off, en_off;
    logic [23:0] w;
    int          bad, n;

    always #5 clk = ~clk;

    adc_frame_uart_tx_if if4 ();
    adc_frame_uart_tx_if if2 ();
    adc_frame_uart_tx_if if87 ();

    assign if4.sample  = smp;  assign if4.sample_valid  = sv; assign if4.tx_en  = en[0]; assign if4.clr_ovr  = clr;
    assign if2.sample  = smp;  assign if2.sample_valid  = sv; assign if2.tx_en  = en[1]; assign if2.clr_ovr  = clr;
    assign if87.sample = smp;  assign if87.sample_valid = sv; assign if87.tx_en = en[2]; assign if87.clr_ovr = clr;

    adc_frame_uart_tx #(.CLK_DIV(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
    adc_frame_uart_tx #(.CLK_DIV(2))  u2  (.clk(clk), .rst(rst), .bus(if2));
    adc_frame_uart_tx #(.CLK_DIV(87)) u87 (.clk(clk), .rst(rst), .bus(if87));

    always_comb begin
        case (sel)
            0:       begin txd_m = if4.txd;  busy_m = if4.busy;  ovr_m = if4.overrun;  end
            1:       begin txd_m = if2.txd;  busy_m = if2.busy;  ovr_m = if2.overrun;  end
            default: begin txd_m = if87.txd; busy_m = if87.busy; ovr_m = if87.overrun; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, then drive any scheduled stimulus for this frame offset
    task automatic step();
        @(negedge clk);
        off++;
        if (busy_m) busy_cnt++;
        sv  = 1'b0;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (off == inj_off[i]) begin
                sv  = 1'b1;
                smp = inj_val[i];
            end
        end
        if (off == clr_off) clr = 1'b1;
        if (off == en_off)  en  = 3'b000;
    endtask

    task automatic clear_inj();
        for (int i = 0; i < 3; i++) inj_off[i] = -1;
        clr_off = -1;
        en_off  = -1;
    endtask

    task automatic start_frame(input logic [15:0] v);
        sv  = 1'b1;
        smp = v;
        off = -1000;
        step();
        off      = 0;
        busy_cnt = busy_m ? 1 : 0;
        smp      = ~v;
        check("start_bit_t1", 32'(txd_m), 32'd0);
        check("busy_rise", 32'(busy_m), 32'd1);
    endtask

    task automatic cont_frame();
        off      = 0;
        busy_cnt = busy_m ? 1 : 0;
    endtask

    task automatic rx_frame(input int d, output logic [23:0] word);
        logic [7:0] b [3];
        int ferr;
        ferr = 0;
        for (int i = 0; i < 3; i++) b[i] = 8'h00;
        for (int k = 0; k < 30; k++) begin
            repeat (d / 2) step();
            if (k % 10 == 0) begin
                if (txd_m !== 1'b0) ferr++;
            end else if (k % 10 == 9) begin
                if (txd_m !== 1'b1) ferr++;
            end else begin
                b[k / 10][(k % 10) - 1] = txd_m;
            end
            repeat (d - d / 2) step();
        end
        word = {b[0], b[1], b[2]};
        check("framing", 32'(ferr), 32'd0);
    endtask

    task automatic idle_watch(input int cycles, output int errs);
        errs = 0;
        repeat (cycles) begin
            step();
            if (txd_m !== 1'b1 || busy_m !== 1'b0) errs++;
        end
    endtask

    initial begin
        sel = 0; en = 3'b001; sv = 1'b0; clr = 1'b0; smp = 16'h0000;
        off = 0; busy_cnt = 0;
        clear_inj();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd_m), 32'd1);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_ovr", 32'(ovr_m), 32'd0);
        rst = 1'b0;

        // 1: quiet line after reset
        idle_watch(200, bad);
        check("t1_idle", 32'(bad), 32'd0);
        check("t1_ovr", 32'(ovr_m), 32'd0);

        // 2: single frame
        clear_inj();
        start_frame(16'h1234);
        rx_frame(4, w);
        check("t2_bytes", 32'(w), 32'h00A51234);
        check("t2_busy_len", 32'(busy_cnt), 32'd120);
        check("t2_idle", 32'(busy_m), 32'd0);
        repeat (5) step();

        // 3: held sample follows with zero gap
        clear_inj();
        inj_off[0] = 50; inj_val[0] = 16'hBEEF;
        start_frame(16'hC0DE);
        rx_frame(4, w);
        check("t3_f1", 32'(w), 32'h00A5C0DE);
        check("t3_nogap_txd", 32'(txd_m), 32'd0);
        check("t3_nogap_busy", 32'(busy_m), 32'd1);
        clear_inj();
        cont_frame();
        rx_frame(4, w);
        check("t3_f2", 32'(w), 32'h00A5BEEF);
        check("t3_busy_len", 32'(busy_cnt), 32'd120);
        check("t3_ovr", 32'(ovr_m), 32'd0);
        repeat (5) step();

        // 3b: strobe in final STOP cycle with empty hold goes straight into the next frame
        clear_inj();
        inj_off[0] = 119; inj_val[0] = 16'h5A3C;
        start_frame(16'h0F0F);
        rx_frame(4, w);
        check("t3b_f1", 32'(w), 32'h00A50F0F);
        check("t3b_nogap", 32'(txd_m), 32'd0);
        clear_inj();
        cont_frame();
        rx_frame(4, w);
        check("t3b_f2", 32'(w), 32'h00A55A3C);
        check("t3b_ovr", 32'(ovr_m), 32'd0);
        check("t3b_idle", 32'(busy_m), 32'd0);
        repeat (5) step();

        // 4: overwrite of held sample, set beats a same-cycle clear
        clear_inj();
        inj_off[0] = 20; inj_val[0] = 16'h0002;
        inj_off[1] = 40; inj_val[1] = 16'h0003;
        clr_off = 40;
        start_frame(16'h0001);
        rx_frame(4, w);
        check("t4_f1", 32'(w), 32'h00A50001);
        check("t4_ovr_set", 32'(ovr_m), 32'd1);
        clear_inj();
        cont_frame();
        rx_frame(4, w);
        check("t4_f2", 32'(w), 32'h00A50003);
        check("t4_idle", 32'(busy_m), 32'd0);
        check("t4_ovr_sticky", 32'(ovr_m), 32'd1);
        clr = 1'b1;
        step();
        check("t4_ovr_clr", 32'(ovr_m), 32'd0);
        repeat (5) step();

        // 5: reset mid-frame drops frame and hold
        clear_inj();
        inj_off[0] = 10; inj_val[0] = 16'h1111;
        start_frame(16'h9999);
        while (off < 36) step();
        rst = 1'b1;
        step();
        check("t5_rst_txd", 32'(txd_m), 32'd1);
        check("t5_rst_busy", 32'(busy_m), 32'd0);
        rst = 1'b0;
        clear_inj();
        idle_watch(200, bad);
        check("t5_discard", 32'(bad), 32'd0);
        start_frame(16'h00FF);
        rx_frame(4, w);
        check("t5_clean", 32'(w), 32'h00A500FF);
        check("t5_busy_len", 32'(busy_cnt), 32'd120);
        repeat (5) step();

        // 6: tx_en low ignores strobes; dropping it mid-frame still sends frame and hold
        clear_inj();
        en = 3'b000;
        for (int i = 0; i < 3; i++) begin
            sv = 1'b1; smp = 16'hA0A0 + 16'(i);
            step();
            repeat (10) step();
        end
        idle_watch(100, bad);
        check("t6_disabled", 32'(bad), 32'd0);
        en = 3'b001;
        clear_inj();
        inj_off[0] = 5; inj_val[0] = 16'h7777;
        en_off = 10;
        start_frame(16'h4321);
        rx_frame(4, w);
        check("t6_f1", 32'(w), 32'h00A54321);
        clear_inj();
        cont_frame();
        rx_frame(4, w);
        check("t6_f2", 32'(w), 32'h00A57777);
        check("t6_idle", 32'(busy_m), 32'd0);
        en = 3'b001;
        repeat (5) step();

        // Bit width and frame length for CLK_DIV = 2 and 87
        for (int s = 1; s < 3; s++) begin
            int d;
            d   = (s == 1) ? 2 : 87;
            sel = s;
            en  = (s == 1) ? 3'b010 : 3'b100;
            clear_inj();
            repeat (5) step();
            start_frame(16'h1234);
            n = 0;
            while (txd_m == 1'b0 && n < 200) begin
                n++;
                step();
            end
            check((s == 1) ? "div2_bitw" : "div87_bitw", 32'(n), 32'(d));
            while (busy_m && off < 40 * d) step();
            check((s == 1) ? "div2_len" : "div87_len", 32'(off), 32'(30 * d));
            repeat (5) step();
            start_frame(16'h1234);
            rx_frame(d, w);
            check((s == 1) ? "div2_bytes" : "div87_bytes", 32'(w), 32'h00A51234);
            check((s == 1) ? "div2_idle" : "div87_idle", 32'(busy_m), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
